// File: rtl/graphic_frame_sequencer.sv
// graphic_frame_sequencer: frame-rate scheduler and AXI-Stream supervisor for graphic_generator.
// Optional stall watchdog is built in when GFX_SEQ_WATCHDOG_EN is defined.
module graphic_frame_sequencer #(
  parameter int PERIOD_W   = 24,
  parameter int DIM_W      = 12,
  parameter int WDT_CYCLES = 4096
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic                ce,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] frame_period,
  input  logic [DIM_W-1:0]    h_active,
  input  logic [DIM_W-1:0]    v_active,
  output logic                gen_start,
  input  logic [15:0]         s_tdata,
  input  logic                s_tvalid,
  input  logic                s_tuser,
  input  logic                s_tlast,
  output logic                s_tready,
  output logic [15:0]         m_tdata,
  output logic                m_tvalid,
  output logic                m_tuser,
  output logic                m_tlast,
  input  logic                m_tready,
  output logic                frame_done,
  output logic [15:0]         frame_count,
  output logic [15:0]         drop_count,
  output logic                err_geom,
  output logic                err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [DIM_W-1:0]    px_q, px_d, ln_q, ln_d;
  logic                first_q, first_d;
  logic                en_q, en_d;
  logic [15:0]         fcnt_q, fcnt_d, drop_q, drop_d;
  logic                err_geom_q, err_geom_d;

  logic [PERIOD_W-1:0] period_m1_s;
  logic [DIM_W-1:0]    h_m1_s, v_m1_s, px_eff_s, ln_eff_s;
  logic                expiry_s, beat_s, rise_s, resync_s, frame_end_s, geom_bad_s, timeout_s;
  logic                busy_s;

  assign period_m1_s = (frame_period == {PERIOD_W{1'b0}}) ? {PERIOD_W{1'b0}}
                                                          : frame_period - PERIOD_W'(1);
  assign h_m1_s      = h_active - DIM_W'(1);
  assign v_m1_s      = v_active - DIM_W'(1);
  assign expiry_s    = ce & enable & (state_q != S_IDLE) & (per_q == {PERIOD_W{1'b0}});
  assign busy_s      = (state_q == S_START) | (state_q == S_STREAM) | (state_q == S_DONE);
  assign beat_s      = ce & (state_q == S_STREAM) & s_tvalid & m_tready;
  assign rise_s      = ce & enable & ~en_q;

  // A stray SOF after the first beat re-anchors the position at pixel 0 of line 0.
  assign resync_s    = ~first_q & s_tuser;
  assign px_eff_s    = resync_s ? {DIM_W{1'b0}} : px_q;
  assign ln_eff_s    = resync_s ? {DIM_W{1'b0}} : ln_q;
  assign frame_end_s = beat_s & s_tlast & (ln_eff_s == v_m1_s);
  assign geom_bad_s  = (first_q & ~s_tuser) | resync_s |
                       (s_tlast ? (px_eff_s != h_m1_s) : (px_eff_s == h_m1_s));

  // Stream gating: transparent only while a frame is being passed through.
  always_comb begin
    m_tdata  = s_tdata;
    m_tvalid = 1'b0;
    m_tuser  = 1'b0;
    m_tlast  = 1'b0;
    s_tready = 1'b0;
    if (state_q == S_STREAM) begin
      m_tvalid = s_tvalid;
      m_tuser  = s_tuser;
      m_tlast  = s_tlast;
      s_tready = m_tready;
    end else begin
      m_tvalid = 1'b0;
      s_tready = 1'b0;
    end
  end

  // Next-state, period counter, line/pixel tracking and status counters.
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    px_d    = px_q;
    ln_d    = ln_q;
    first_d = first_q;
    en_d    = en_q;
    fcnt_d  = fcnt_q;
    drop_d  = drop_q;
    if (ce) begin
      en_d = enable;
      if ((state_q == S_IDLE) && enable) begin
        per_d = period_m1_s;
      end else if (expiry_s) begin
        per_d = period_m1_s;
      end else if (enable && (state_q != S_IDLE)) begin
        per_d = per_q - PERIOD_W'(1);
      end else begin
        per_d = per_q;
      end
      if (expiry_s && busy_s && (drop_q != 16'hFFFF)) begin
        drop_d = drop_q + 16'd1;
      end else begin
        drop_d = drop_q;
      end
      case (state_q)
        S_IDLE: begin
          if (enable) state_d = S_WAIT;
          else        state_d = S_IDLE;
        end
        S_WAIT: begin
          if (!enable)       state_d = S_IDLE;
          else if (expiry_s) state_d = S_START;
          else               state_d = S_WAIT;
        end
        S_START: begin
          px_d    = {DIM_W{1'b0}};
          ln_d    = {DIM_W{1'b0}};
          first_d = 1'b1;
          state_d = S_STREAM;
        end
        S_STREAM: begin
          if (beat_s) begin
            first_d = 1'b0;
            if (s_tlast) begin
              px_d = {DIM_W{1'b0}};
              ln_d = ln_eff_s + DIM_W'(1);
            end else begin
              px_d = px_eff_s + DIM_W'(1);
              ln_d = ln_eff_s;
            end
          end else begin
            first_d = first_q;
          end
          if (timeout_s)        state_d = enable ? S_WAIT : S_IDLE;
          else if (frame_end_s) state_d = S_DONE;
          else                  state_d = S_STREAM;
        end
        S_DONE: begin
          fcnt_d  = fcnt_q + 16'd1;
          state_d = enable ? S_WAIT : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
    if (beat_s && geom_bad_s) begin
      err_geom_d = 1'b1;
    end else if (rise_s) begin
      err_geom_d = 1'b0;
    end else begin
      err_geom_d = err_geom_q;
    end
  end

  // State and status registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= S_IDLE;
      per_q      <= {PERIOD_W{1'b0}};
      px_q       <= {DIM_W{1'b0}};
      ln_q       <= {DIM_W{1'b0}};
      first_q    <= 1'b0;
      en_q       <= 1'b0;
      fcnt_q     <= 16'd0;
      drop_q     <= 16'd0;
      err_geom_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_q      <= per_d;
      px_q       <= px_d;
      ln_q       <= ln_d;
      first_q    <= first_d;
      en_q       <= en_d;
      fcnt_q     <= fcnt_d;
      drop_q     <= drop_d;
      err_geom_q <= err_geom_d;
    end
  end

`ifdef GFX_SEQ_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             err_to_q, err_to_d;

  assign timeout_s = ce & (state_q == S_STREAM) & ~beat_s & (wdt_q == WDT_W'(WDT_CYCLES - 1));

  // Stall counter over beat-less STREAM cycles and the sticky timeout flag.
  always_comb begin
    wdt_d = wdt_q;
    if (!ce) begin
      wdt_d = wdt_q;
    end else if ((state_q == S_START) || beat_s) begin
      wdt_d = {WDT_W{1'b0}};
    end else if (state_q == S_STREAM) begin
      wdt_d = wdt_q + WDT_W'(1);
    end else begin
      wdt_d = wdt_q;
    end
    if (timeout_s)   err_to_d = 1'b1;
    else if (rise_s) err_to_d = 1'b0;
    else             err_to_d = err_to_q;
  end

  // Watchdog registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wdt_q    <= {WDT_W{1'b0}};
      err_to_q <= 1'b0;
    end else begin
      wdt_q    <= wdt_d;
      err_to_q <= err_to_d;
    end
  end

  assign err_timeout = err_to_q;
`else
  assign timeout_s   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign gen_start   = (state_q == S_START);
  assign frame_done  = (state_q == S_DONE);
  assign frame_count = fcnt_q;
  assign drop_count  = drop_q;
  assign err_geom    = err_geom_q;

endmodule

// File: tb/tb_graphic_frame_sequencer.sv
// Directed bench for graphic_frame_sequencer: a table of frame scenarios plus hand-written
// sequences for geometry errors, async reset, clock enable and stall behaviour.
`timescale 1ns/1ps
module tb_graphic_frame_sequencer;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        ce = 1'b0;
  logic        enable = 1'b0;
  logic [23:0] frame_period = 24'd0;
  logic [11:0] h_active = 12'd4;
  logic [11:0] v_active = 12'd2;
  logic        gen_start;
  logic [15:0] s_tdata = 16'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tuser = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid, m_tuser, m_tlast;
  logic        m_tready = 1'b1;
  logic        frame_done;
  logic [15:0] frame_count, drop_count;
  logic        err_geom, err_timeout;

  graphic_frame_sequencer #(.PERIOD_W(24), .DIM_W(12), .WDT_CYCLES(64)) dut (
    .hclk(hclk), .hresetn(hresetn), .ce(ce), .enable(enable),
    .frame_period(frame_period), .h_active(h_active), .v_active(v_active),
    .gen_start(gen_start),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .frame_done(frame_done), .frame_count(frame_count), .drop_count(drop_count),
    .err_geom(err_geom), .err_timeout(err_timeout)
  );

  always #5 hclk = ~hclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  typedef struct {
    int h, v, period, bad_px, gap, ce_at, en_drop_at, frames;
    bit toggle, exp_geom;
    int exp_drops, exp_interval;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hresetn = 1'b0; enable = 1'b0; ce = 1'b1; m_tready = 1'b1;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = 16'd0;
    repeat (3) step();
    hresetn = 1'b1;
    step();
  endtask

  task automatic wait_start(input int limit, output bit found, output int at);
    found = 1'b0;
    at = 0;
    for (int i = 0; i < limit; i++) begin
      if (gen_start) begin
        found = 1'b1;
        at = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input bit u, input bit l, input bit toggle);
    bit taken = 1'b0;
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    for (int t = 0; t < 32 && !taken; t++) begin
      if (toggle) m_tready = ~m_tready;
      #1;
      check("pass_tready", s_tready, m_tready);
      check("pass_tvalid", m_tvalid, 1);
      check("pass_tdata", m_tdata, d);
      check("pass_tuser", m_tuser, u);
      check("pass_tlast", m_tlast, l);
      taken = s_tready;
      step();
    end
    s_tvalid = 1'b0;
    check("beat_accepted", taken, 1);
  endtask

  // Called in the START cycle; returns in the cycle after the last beat.
  task automatic stream_frame(input vec_t vt);
    int k = 0;
    int len;
    step();
    for (int ln = 0; ln < vt.v; ln++) begin
      len = (ln == 0 && vt.bad_px >= 0) ? vt.bad_px + 1 : vt.h;
      for (int p = 0; p < len; p++) begin
        if (k == vt.en_drop_at) enable = 1'b0;
        for (int g = 0; g < vt.gap; g++) step();
        if (k == vt.ce_at) begin
          s_tdata = 16'hA000 + 16'(k); s_tuser = (k == 0); s_tlast = (p == len - 1);
          s_tvalid = 1'b1; ce = 1'b0;
          for (int c = 0; c < 4; c++) begin
            #1;
            check("ce_hold_tready", s_tready, m_tready);
            check("ce_hold_done", frame_done, 0);
            step();
          end
          ce = 1'b1;
        end
        send_beat(16'hA000 + 16'(k), k == 0, p == len - 1, vt.toggle);
        k++;
      end
    end
    m_tready = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    bit found;
    int at, prev, n;

    vecs[0] = '{h:4, v:2, period:100, bad_px:-1, gap:0, ce_at:-1, en_drop_at:-1, frames:3,
                toggle:0, exp_geom:0, exp_drops:0, exp_interval:100};
    vecs[1] = '{h:4, v:2, period:100, bad_px:-1, gap:0, ce_at:-1, en_drop_at:-1, frames:1,
                toggle:1, exp_geom:0, exp_drops:0, exp_interval:0};
    vecs[2] = '{h:4, v:2, period:100, bad_px:2, gap:0, ce_at:-1, en_drop_at:-1, frames:1,
                toggle:0, exp_geom:1, exp_drops:0, exp_interval:0};
    vecs[3] = '{h:4, v:2, period:10, bad_px:-1, gap:2, ce_at:-1, en_drop_at:-1, frames:2,
                toggle:0, exp_geom:0, exp_drops:4, exp_interval:30};
    vecs[4] = '{h:3, v:3, period:0, bad_px:-1, gap:0, ce_at:-1, en_drop_at:-1, frames:2,
                toggle:0, exp_geom:0, exp_drops:22, exp_interval:12};
    vecs[5] = '{h:4, v:2, period:100, bad_px:-1, gap:0, ce_at:3, en_drop_at:-1, frames:1,
                toggle:0, exp_geom:0, exp_drops:0, exp_interval:0};
    vecs[6] = '{h:4, v:2, period:100, bad_px:-1, gap:0, ce_at:-1, en_drop_at:3, frames:1,
                toggle:0, exp_geom:0, exp_drops:0, exp_interval:0};

    do_reset();
    check("rst_gen_start", gen_start, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_err_geom", err_geom, 0);
    check("rst_err_timeout", err_timeout, 0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      frame_period = 24'(vecs[i].period);
      h_active = 12'(vecs[i].h);
      v_active = 12'(vecs[i].v);
      enable = 1'b1;
      prev = -1;
      for (int f = 0; f < vecs[i].frames; f++) begin
        wait_start(400, found, at);
        check($sformatf("v%0d_start_seen", i), found, 1);
        if (!found) break;
        if (prev >= 0 && vecs[i].exp_interval != 0)
          check($sformatf("v%0d_start_interval", i), at - prev, vecs[i].exp_interval);
        prev = at;
        stream_frame(vecs[i]);
        check($sformatf("v%0d_frame_done", i), frame_done, 1);
        step();
        check($sformatf("v%0d_frame_done_clear", i), frame_done, 0);
      end
      check($sformatf("v%0d_frame_count", i), frame_count, vecs[i].frames);
      check($sformatf("v%0d_drop_count", i), drop_count, vecs[i].exp_drops);
      check($sformatf("v%0d_err_geom", i), err_geom, vecs[i].exp_geom);
      check($sformatf("v%0d_err_timeout", i), err_timeout, 0);
      if (vecs[i].en_drop_at >= 0) begin
        found = 1'b0;
        repeat (250) begin
          if (gen_start) found = 1'b1;
          step();
        end
        check("disabled_no_start", found, 0);
        check("disabled_s_tready", s_tready, 0);
      end
    end

    // Stray SOF mid-line: flagged, then position resyncs so the rest of the line is clean.
    do_reset();
    frame_period = 24'd20; h_active = 12'd4; v_active = 12'd1; enable = 1'b1;
    wait_start(100, found, at);
    check("sof_start_seen", found, 1);
    step();
    send_beat(16'h0100, 1'b1, 1'b0, 1'b0);
    send_beat(16'h0101, 1'b0, 1'b0, 1'b0);
    check("sof_clean_so_far", err_geom, 0);
    send_beat(16'h0102, 1'b1, 1'b0, 1'b0);
    check("sof_mid_line_err", err_geom, 1);
    enable = 1'b0; step();
    check("sof_err_sticky", err_geom, 1);
    enable = 1'b1; step();
    check("sof_err_clear_on_rise", err_geom, 0);
    send_beat(16'h0103, 1'b0, 1'b0, 1'b0);
    send_beat(16'h0104, 1'b0, 1'b0, 1'b0);
    send_beat(16'h0105, 1'b0, 1'b1, 1'b0);
    check("sof_resync_frame_done", frame_done, 1);
    check("sof_resync_no_err", err_geom, 0);

    // Single-pixel frame whose only beat lacks SOF.
    h_active = 12'd1;
    step();
    wait_start(100, found, at);
    check("nosof_start_seen", found, 1);
    step();
    send_beat(16'h0200, 1'b0, 1'b1, 1'b0);
    check("nosof_frame_done", frame_done, 1);
    check("nosof_err_geom", err_geom, 1);

    // Async reset mid-frame abandons the frame; the next frame runs normally.
    do_reset();
    frame_period = 24'd100; h_active = 12'd4; v_active = 12'd2; enable = 1'b1;
    wait_start(400, found, at);
    check("arst_first_start", found, 1);
    stream_frame(vecs[0]);
    step();
    check("arst_pre_count", frame_count, 1);
    wait_start(400, found, at);
    check("arst_second_start", found, 1);
    step();
    send_beat(16'hA000, 1'b1, 1'b0, 1'b0);
    send_beat(16'hA001, 1'b0, 1'b0, 1'b0);
    s_tvalid = 1'b1;
    #2 hresetn = 1'b0;
    #1;
    check("arst_s_tready", s_tready, 0);
    check("arst_m_tvalid", m_tvalid, 0);
    check("arst_frame_count", frame_count, 0);
    s_tvalid = 1'b0;
    step();
    hresetn = 1'b1;
    wait_start(400, found, at);
    check("arst_restart", found, 1);
    stream_frame(vecs[0]);
    check("arst_frame_done", frame_done, 1);
    step();
    check("arst_post_count", frame_count, 1);
    check("arst_post_geom", err_geom, 0);

    // Generator stalls after the start pulse.
    do_reset();
    frame_period = 24'd100; h_active = 12'd4; v_active = 12'd2; enable = 1'b1;
    wait_start(400, found, at);
    check("stall_start_seen", found, 1);
    s_tvalid = 1'b0;
`ifdef GFX_SEQ_WATCHDOG_EN
    n = 0;
    while (!err_timeout && n < 300) begin
      step();
      n++;
    end
    check("wdt_cycles_to_timeout", n, 65);
    check("wdt_frame_count", frame_count, 0);
    check("wdt_s_tready", s_tready, 0);
    check("wdt_frame_done", frame_done, 0);
    wait_start(400, found, at);
    check("wdt_restart_from_wait", found, 1);
`else
    n = 0;
    repeat (150) begin
      step();
      n++;
    end
    check("stall_cycles", n, 150);
    check("stall_no_timeout", err_timeout, 0);
    check("stall_still_streaming", s_tready, 1);
    check("stall_drop_count", drop_count, 1);
    check("stall_frame_count", frame_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
